// File: rtl/otter_intr_pkg.sv
// Shared types and helpers for the OTTER interrupt controller.
// The INTR_SYNC_EN macro is not used here; it only affects intr_edge_det.
package otter_intr_pkg;

  // Hard upper bound on the number of interrupt sources.
  localparam int MAX_SRC = 16;

  // Request FSM: waiting for a request, driving intr, or servicing an ISR.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    IN_ISR = 2'd2
  } intr_state_t;

  // Priority encoder: returns the lowest set index (0 when nothing is set).
  function automatic int prio_enc(input logic [MAX_SRC-1:0] elig);
    int idx;
    idx = 0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (elig[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/otter_intr_ctrl_edge_det.sv
// Per-bit rising-edge detector for the interrupt lines.
// With INTR_SYNC_EN defined, every line first passes through a 2-flop
// synchroniser (adds two cycles of latency); otherwise irq_in must already
// be synchronous to clk.
module intr_edge_det #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] irq_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] irq_s;
  logic [WIDTH-1:0] irq_d_q;
  logic [WIDTH-1:0] irq_d_d;

`ifdef INTR_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-stage synchroniser per line; cleared on reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign irq_d_d = irq_s;

  // History register: value of each line at the previous edge.
  always_ff @(posedge clk) begin
    if (RST) irq_d_q <= '0;
    else     irq_d_q <= irq_d_d;
  end

  // A line produces an event only on a low-to-high transition.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rise
      assign rise[gi] = irq_s[gi] & ~irq_d_q[gi];
    end
  endgenerate

endmodule

// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller: edge-detects NUM_SRC lines into pending bits,
// masks and prioritises them (lowest index wins) and drives a registered
// intr request to the control unit, holding off new requests until mret.
// Optional macro INTR_SYNC_EN adds a 2-flop synchroniser on irq_in.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int                 NUM_SRC  = 4,
  parameter logic [NUM_SRC-1:0] MASK_RST = '0,
  localparam int                CW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_taken,
  input  logic               mret,
  output logic               intr,
  output logic [CW-1:0]      cause_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  intr_state_t        state_q, state_d;
  logic               intr_q, intr_d;
  logic [CW-1:0]      cause_q, cause_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [MAX_SRC-1:0] elig_ext;
  logic               req;
  logic [CW-1:0]      win;

  intr_edge_det #(
    .WIDTH (NUM_SRC)
  ) u_edge_det (
    .clk    (clk),
    .RST    (RST),
    .irq_in (irq_in),
    .rise   (rise)
  );

  // Eligibility and arbitration among masked pending sources.
  always_comb begin
    elig_ext                = '0;
    elig                    = pending_q & mask_q;
    elig_ext[NUM_SRC-1:0]   = elig;
    req                     = mie & (|elig);
    win                     = CW'(prio_enc(elig_ext));
  end

  // Next-state logic: FSM, intr, cause, pending clear and mask write.
  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    cause_d = cause_q;
    clr     = '0;
    mask_d  = mask_we ? mask_wdata : mask_q;

    case (state_q)
      IDLE: begin
        intr_d = 1'b0;
        if (req) begin
          state_d = ASSERT;
          cause_d = win;
          intr_d  = 1'b1;
        end
      end
      ASSERT: begin
        if (int_taken) begin
          // Request consumed; cause stays visible for the ISR.
          state_d      = IN_ISR;
          intr_d       = 1'b0;
          clr[cause_q] = 1'b1;
        end else if (!req || !elig[cause_q]) begin
          // Request withdrawn by mask or mie; pending bit is kept.
          state_d = IDLE;
          intr_d  = 1'b0;
        end else begin
          // Cause is frozen while asserting, no re-arbitration.
          intr_d = 1'b1;
        end
      end
      IN_ISR: begin
        intr_d = 1'b0;
        if (mret) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        intr_d  = 1'b0;
      end
    endcase

    // A new edge on the bit being cleared wins over the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      intr_q    <= 1'b0;
      cause_q   <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      state_q   <= state_d;
      intr_q    <= intr_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  assign intr     = intr_q;
  assign cause_id = cause_q;
  assign pending  = pending_q;
  assign mask     = mask_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed testbench for otter_intr_ctrl (NUM_SRC=4, MASK_RST=0).
// The cycle table assumes the direct (unsynchronised) build; the latency and
// held-line sequences adapt to INTR_SYNC_EN.
module tb_otter_intr_ctrl;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] irq_in = '0;
  logic       mie = 1'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       int_taken = 1'b0;
  logic       mret = 1'b0;
  logic       intr;
  logic [1:0] cause_id;
  logic [3:0] pending;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

`ifdef INTR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  otter_intr_ctrl #(
    .NUM_SRC  (4),
    .MASK_RST (4'b0000)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .irq_in     (irq_in),
    .mie        (mie),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_taken  (int_taken),
    .mret       (mret),
    .intr       (intr),
    .cause_id   (cause_id),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] irq;
    logic       mie;
    logic       mwe;
    logic [3:0] mwd;
    logic       tk;
    logic       mret;
    logic       ex_intr;
    logic [1:0] ex_cause;
    logic [3:0] ex_pend;
    logic [3:0] ex_mask;
  } vec_t;

  vec_t vt[$];

  task automatic v(input logic rst, input logic [3:0] irq, input logic ie,
                   input logic mwe, input logic [3:0] mwd, input logic tk,
                   input logic mr, input logic ei, input logic [1:0] ec,
                   input logic [3:0] ep, input logic [3:0] em);
    vec_t e;
    e.rst = rst; e.irq = irq; e.mie = ie; e.mwe = mwe; e.mwd = mwd;
    e.tk = tk; e.mret = mr; e.ex_intr = ei; e.ex_cause = ec;
    e.ex_pend = ep; e.ex_mask = em;
    vt.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] irq, input logic ie,
                       input logic mwe, input logic [3:0] mwd, input logic tk,
                       input logic mr);
    RST = rst; irq_in = irq; mie = ie; mask_we = mwe; mask_wdata = mwd;
    int_taken = tk; mret = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int k;

`ifndef INTR_SYNC_EN
    //  rst irq     mie mwe mwd     tk mret | intr cause pend    mask
    // Reset with lines high, then release with mask still zero
    v(1, 4'b1111, 0, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0000, 4'b0000);
    v(1, 4'b1111, 0, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0000, 4'b0000);
    v(0, 4'b1111, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b1111, 4'b0000);
    v(0, 4'b1111, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b1111, 4'b0000);
    v(1, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0000, 4'b0000);
    // Basic single source 2
    v(0, 4'b0000, 1, 1, 4'b0100, 0, 0,   0, 2'd0, 4'b0000, 4'b0100);
    v(0, 4'b0100, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0100, 4'b0100);
    v(0, 4'b0100, 1, 0, 4'b0000, 0, 0,   1, 2'd2, 4'b0100, 4'b0100);
    v(0, 4'b0100, 1, 0, 4'b0000, 1, 0,   0, 2'd2, 4'b0000, 4'b0100);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 2'd2, 4'b0000, 4'b0100);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 1,   0, 2'd2, 4'b0000, 4'b0100);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 2'd2, 4'b0000, 4'b0100);
    // Priority / freeze: cause 3 held while source 0 arrives
    v(0, 4'b0000, 1, 1, 4'b1111, 0, 0,   0, 2'd2, 4'b0000, 4'b1111);
    v(0, 4'b1000, 1, 0, 4'b0000, 0, 0,   0, 2'd2, 4'b1000, 4'b1111);
    v(0, 4'b1000, 1, 0, 4'b0000, 0, 0,   1, 2'd3, 4'b1000, 4'b1111);
    v(0, 4'b1001, 1, 0, 4'b0000, 0, 0,   1, 2'd3, 4'b1001, 4'b1111);
    v(0, 4'b1001, 1, 0, 4'b0000, 0, 0,   1, 2'd3, 4'b1001, 4'b1111);
    v(0, 4'b1001, 1, 0, 4'b0000, 1, 0,   0, 2'd3, 4'b0001, 4'b1111);
    v(0, 4'b1001, 1, 0, 4'b0000, 0, 1,   0, 2'd3, 4'b0001, 4'b1111);
    v(0, 4'b1001, 1, 0, 4'b0000, 0, 0,   1, 2'd0, 4'b0001, 4'b1111);
    v(0, 4'b1001, 1, 0, 4'b0000, 1, 0,   0, 2'd0, 4'b0000, 4'b1111);
    v(0, 4'b1001, 1, 0, 4'b0000, 0, 1,   0, 2'd0, 4'b0000, 4'b1111);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0000, 4'b1111);
    // Withdraw via mie, then restore
    v(0, 4'b0010, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0010, 4'b1111);
    v(0, 4'b0010, 1, 0, 4'b0000, 0, 0,   1, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0010, 0, 0, 4'b0000, 0, 0,   0, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0010, 0, 0, 4'b0000, 0, 0,   0, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0010, 1, 0, 4'b0000, 0, 0,   1, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0010, 1, 0, 4'b0000, 1, 0,   0, 2'd1, 4'b0000, 4'b1111);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 1,   0, 2'd1, 4'b0000, 4'b1111);
    // Withdraw via mask; stray mret/int_taken ignored
    v(0, 4'b0010, 1, 0, 4'b0000, 0, 0,   0, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0010, 1, 0, 4'b0000, 0, 1,   1, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0010, 1, 0, 4'b0000, 0, 1,   1, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0010, 1, 1, 4'b1101, 0, 0,   1, 2'd1, 4'b0010, 4'b1101);
    v(0, 4'b0010, 1, 0, 4'b0000, 0, 0,   0, 2'd1, 4'b0010, 4'b1101);
    v(0, 4'b0010, 1, 0, 4'b0000, 1, 0,   0, 2'd1, 4'b0010, 4'b1101);
    v(0, 4'b0000, 1, 1, 4'b1111, 0, 0,   0, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   1, 2'd1, 4'b0010, 4'b1111);
    v(0, 4'b0000, 1, 0, 4'b0000, 1, 0,   0, 2'd1, 4'b0000, 4'b1111);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 1,   0, 2'd1, 4'b0000, 4'b1111);
    // Set/clear collision on source 2
    v(0, 4'b0100, 1, 0, 4'b0000, 0, 0,   0, 2'd1, 4'b0100, 4'b1111);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   1, 2'd2, 4'b0100, 4'b1111);
    v(0, 4'b0100, 1, 0, 4'b0000, 1, 0,   0, 2'd2, 4'b0100, 4'b1111);
    v(0, 4'b0100, 1, 0, 4'b0000, 0, 0,   0, 2'd2, 4'b0100, 4'b1111);
    v(0, 4'b0100, 1, 0, 4'b0000, 0, 1,   0, 2'd2, 4'b0100, 4'b1111);
    v(0, 4'b0100, 1, 0, 4'b0000, 0, 0,   1, 2'd2, 4'b0100, 4'b1111);
    v(0, 4'b0100, 1, 0, 4'b0000, 1, 0,   0, 2'd2, 4'b0000, 4'b1111);
    v(0, 4'b0100, 1, 0, 4'b0000, 1, 0,   0, 2'd2, 4'b0000, 4'b1111);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 1,   0, 2'd2, 4'b0000, 4'b1111);
    // Reset mid-ASSERT abandons everything
    v(0, 4'b0001, 1, 0, 4'b0000, 0, 0,   0, 2'd2, 4'b0001, 4'b1111);
    v(0, 4'b0001, 1, 0, 4'b0000, 0, 0,   1, 2'd0, 4'b0001, 4'b1111);
    v(1, 4'b0001, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0000, 4'b0000);
    v(0, 4'b0001, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0001, 4'b0000);
    v(0, 4'b0001, 1, 0, 4'b0000, 0, 0,   0, 2'd0, 4'b0001, 4'b0000);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].irq, vt[i].mie, vt[i].mwe, vt[i].mwd,
            vt[i].tk, vt[i].mret);
      step();
      check("intr",     i, 32'(intr),     32'(vt[i].ex_intr));
      check("cause_id", i, 32'(cause_id), 32'(vt[i].ex_cause));
      check("pending",  i, 32'(pending),  32'(vt[i].ex_pend));
      check("mask",     i, 32'(mask),     32'(vt[i].ex_mask));
      $display("vec %0d: irq=%b tk=%b mret=%b -> intr=%b cause=%0d pend=%b mask=%b",
               i, vt[i].irq, vt[i].tk, vt[i].mret, intr, cause_id, pending, mask);
    end
`endif

    // Latency sequence: reset, enable source 0, raise it once.
    drive(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    step();
    step();
    check("rst_intr", 100, 32'(intr), 32'd0);
    check("rst_mask", 100, 32'(mask), 32'd0);
    drive(0, 4'b0000, 1, 1, 4'b0001, 0, 0);
    step();
    drive(0, 4'b0001, 1, 0, 4'b0000, 0, 0);
    cyc = 0;
    while (intr !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
      if (cyc == LAT - 1) check("lat_pend", 101, 32'(pending), 32'b0001);
    end
    check("latency", 102, 32'(cyc), 32'(LAT));
    check("lat_cause", 102, 32'(cause_id), 32'd0);
    $display("latency: intr after %0d edges", cyc);

    // Keep the line high: service once, then no further event.
    drive(0, 4'b0001, 1, 0, 4'b0000, 1, 0);
    step();
    check("taken_intr", 103, 32'(intr), 32'd0);
    check("taken_pend", 103, 32'(pending), 32'd0);
    drive(0, 4'b0001, 1, 0, 4'b0000, 0, 1);
    step();
    drive(0, 4'b0001, 1, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("held_intr", 104 + i, 32'(intr), 32'd0);
      check("held_pend", 104 + i, 32'(pending), 32'd0);
    end
    $display("held line: intr=%b pending=%b after hold", intr, pending);

    // Drop and re-raise: a fresh edge must request again.
    drive(0, 4'b0000, 1, 0, 4'b0000, 0, 0);
    for (int i = 0; i < LAT; i++) step();
    drive(0, 4'b0001, 1, 0, 4'b0000, 0, 0);
    k = 0;
    while (intr !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("reraise", 110, 32'(k), 32'(LAT));
    $display("re-raise: intr after %0d edges", k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
